y86_register_file: RTL and testbench

- Register file at the receiving end of the write-back stage's two write ports. Holds the eight 32-bit Y86 registers and accepts up to two writes per clock.
- Serves two read ports to decode, with optional same-cycle write-to-read bypass.
- Contains a register-dump sequencer that streams all registers out one per cycle for debug and testbench checking.

---
 rtl/y86_register_file.sv | 136 +++++++++++++
 tb/tb_y86_register_file.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/y86_register_file.sv
// Y86 register file: eight registers, two write ports, two read ports.
// Ports: clock/reset, regWrite/regReg/regValue x2, readReg/readValue x2, dump_* stream.
module y86_register_file #(
  parameter int              WIDTH      = 32,
  parameter int              SP_INDEX   = 6,
  parameter logic [WIDTH-1:0] STACK_INIT = 32'h0000_0100,
  parameter bit              BYPASS     = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             regWrite1,
  input  logic [3:0]       regReg1,
  input  logic [WIDTH-1:0] regValue1,
  input  logic             regWrite2,
  input  logic [3:0]       regReg2,
  input  logic [WIDTH-1:0] regValue2,
  input  logic [3:0]       readReg1,
  output logic [WIDTH-1:0] readValue1,
  input  logic [3:0]       readReg2,
  output logic [WIDTH-1:0] readValue2,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  output logic [2:0]       dump_index,
  output logic [WIDTH-1:0] dump_value,
  output logic             dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] regs [8];

  state_t           state, state_n;
  logic             busy_n, valid_n, done_n;
  logic [2:0]       index_n;
  logic [WIDTH-1:0] value_n;

  // Port 2 is applied last so it wins a same-register conflict
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      regs[3'(SP_INDEX)] <= STACK_INIT;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (regWrite2 && regReg2 == 4'(i)) begin
          regs[i] <= regValue2;
        end else if (regWrite1 && regReg1 == 4'(i)) begin
          regs[i] <= regValue1;
        end
      end
    end
  end

  function automatic logic [WIDTH-1:0] rd(input logic [3:0] id);
    logic [WIDTH-1:0] v;
    v = '0;
    if (!id[3]) begin
      v = regs[id[2:0]];
      if (BYPASS) begin
        if (regWrite2 && regReg2 == id) begin
          v = regValue2;
        end else if (regWrite1 && regReg1 == id) begin
          v = regValue1;
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    readValue1 = rd(readReg1);
    readValue2 = rd(readReg2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_index <= '0;
      dump_value <= '0;
    end else begin
      state      <= state_n;
      dump_busy  <= busy_n;
      dump_valid <= valid_n;
      dump_done  <= done_n;
      dump_index <= index_n;
      dump_value <= value_n;
    end
  end

  // dump_index doubles as the scan counter; values are the
  // stored contents before this edge's writes land
  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    done_n  = 1'b0;
    index_n = dump_index;
    value_n = dump_value;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          state_n = SCAN;
          valid_n = 1'b1;
          index_n = 3'd0;
          value_n = regs[0];
        end
      end
      SCAN: begin
        if (dump_index == 3'd7) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          valid_n = 1'b1;
          index_n = dump_index + 3'd1;
          value_n = regs[index_n];
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_y86_register_file.sv
// Testbench for y86_register_file: bypass and stored-only instances
// driven from a shared vector table plus dump corner-case sequences.
module tb_y86_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic        regWrite1, regWrite2;
  logic [3:0]  regReg1, regReg2, readReg1, readReg2;
  logic [31:0] regValue1, regValue2;
  logic [31:0] rv1, rv2, nv1, nv2;
  logic        dump_start;
  logic        busy, valid, done;
  logic [2:0]  idx;
  logic [31:0] dval;
  logic        n_busy, n_valid, n_done;
  logic [2:0]  n_idx;
  logic [31:0] n_dval;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  y86_register_file #(.BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset),
    .regWrite1(regWrite1), .regReg1(regReg1), .regValue1(regValue1),
    .regWrite2(regWrite2), .regReg2(regReg2), .regValue2(regValue2),
    .readReg1(readReg1), .readValue1(rv1),
    .readReg2(readReg2), .readValue2(rv2),
    .dump_start(dump_start), .dump_busy(busy), .dump_valid(valid),
    .dump_index(idx), .dump_value(dval), .dump_done(done)
  );

  y86_register_file #(.BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset),
    .regWrite1(regWrite1), .regReg1(regReg1), .regValue1(regValue1),
    .regWrite2(regWrite2), .regReg2(regReg2), .regValue2(regValue2),
    .readReg1(readReg1), .readValue1(nv1),
    .readReg2(readReg2), .readValue2(nv2),
    .dump_start(dump_start), .dump_busy(n_busy), .dump_valid(n_valid),
    .dump_index(n_idx), .dump_value(n_dval), .dump_done(n_done)
  );

  typedef struct {
    logic        w1;
    logic [3:0]  r1;
    logic [31:0] v1;
    logic        w2;
    logic [3:0]  r2;
    logic [31:0] v2;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [31:0] ea_byp;
    logic [31:0] eb_byp;
    logic [31:0] ea_nb;
    logic [31:0] eb_nb;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] exp_regs [8];
  logic [31:0] seen [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    regWrite1 = 0; regReg1 = 4'hF; regValue1 = 0;
    regWrite2 = 0; regReg2 = 4'hF; regValue2 = 0;
    readReg1 = 0; readReg2 = 0; dump_start = 0;
  endtask

  // Full dump with no disturbance; checks timing and contents
  task automatic full_dump(input string tag);
    dump_start = 1;
    step();
    dump_start = 0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " valid"}, 32'(valid), 32'd1);
      chk({tag, " index"}, 32'(idx), 32'(k));
      chk({tag, " value"}, dval, exp_regs[k]);
      chk({tag, " done_low"}, 32'(done), 32'd0);
      step();
    end
    chk({tag, " done_busy"}, 32'(busy), 32'd1);
    chk({tag, " done_valid"}, 32'(valid), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " hold_index"}, 32'(idx), 32'd7);
    step();
    chk({tag, " end_busy"}, 32'(busy), 32'd0);
    chk({tag, " end_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nvalid, ndone;
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst index", 32'(idx), 32'd0);
    chk("rst value", dval, 32'd0);

    for (int i = 0; i < 8; i++) exp_regs[i] = 0;
    exp_regs[6] = 32'h100;
    full_dump("reset_dump");

    vecs[0] = '{1, 4'h0, 32'hDEAD_BEEF, 0, 4'hF, 0, 4'h0, 4'h6,
                32'hDEAD_BEEF, 32'h100, 32'h0, 32'h100};
    vecs[1] = '{0, 4'hF, 0, 0, 4'hF, 0, 4'h0, 4'h1,
                32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1, 4'h6, 32'h104, 1, 4'h6, 32'h55, 4'h6, 4'h6,
                32'h55, 32'h55, 32'h100, 32'h100};
    vecs[3] = '{0, 4'hF, 0, 0, 4'hF, 0, 4'h6, 4'h0,
                32'h55, 32'hDEAD_BEEF, 32'h55, 32'hDEAD_BEEF};
    vecs[4] = '{1, 4'hF, 32'h1234, 0, 4'hF, 0, 4'hF, 4'h9,
                0, 0, 0, 0};
    vecs[5] = '{1, 4'h2, 32'h11, 1, 4'h3, 32'h22, 4'h2, 4'h3,
                32'h11, 32'h22, 0, 0};
    vecs[6] = '{0, 4'hF, 0, 0, 4'hF, 0, 4'h2, 4'h3,
                32'h11, 32'h22, 32'h11, 32'h22};
    vecs[7] = '{0, 4'hF, 0, 1, 4'h9, 32'hABC, 4'h9, 4'h7,
                0, 0, 0, 0};

    for (int i = 0; i < 8; i++) begin
      regWrite1 = vecs[i].w1; regReg1 = vecs[i].r1; regValue1 = vecs[i].v1;
      regWrite2 = vecs[i].w2; regReg2 = vecs[i].r2; regValue2 = vecs[i].v2;
      readReg1 = vecs[i].a; readReg2 = vecs[i].b;
      #1;
      chk($sformatf("vec%0d byp rd1", i), rv1, vecs[i].ea_byp);
      chk($sformatf("vec%0d byp rd2", i), rv2, vecs[i].eb_byp);
      chk($sformatf("vec%0d nb rd1", i), nv1, vecs[i].ea_nb);
      chk($sformatf("vec%0d nb rd2", i), nv2, vecs[i].eb_nb);
      step();
    end
    idle_inputs();

    exp_regs[0] = 32'hDEAD_BEEF;
    exp_regs[2] = 32'h11;
    exp_regs[3] = 32'h22;
    exp_regs[6] = 32'h55;
    full_dump("after_writes");

    // Second start during scan ignored; reg 7 written mid-scan
    for (int i = 0; i < 8; i++) seen[i] = 32'hFFFF_FFFF;
    nvalid = 0;
    ndone = 0;
    dump_start = 1;
    step();
    dump_start = 0;
    for (int c = 1; c <= 14; c++) begin
      if (valid) begin
        nvalid++;
        seen[idx] = dval;
      end
      if (done) ndone++;
      dump_start = (c == 3);
      regWrite1 = (c == 4);
      regReg1 = 4'h7;
      regValue1 = 32'hA5;
      step();
    end
    idle_inputs();
    chk("overlap valid count", 32'(nvalid), 32'd8);
    chk("overlap done count", 32'(ndone), 32'd1);
    chk("overlap idx7", seen[7], 32'hA5);
    chk("overlap idx0", seen[0], 32'hDEAD_BEEF);
    chk("overlap idx6", seen[6], 32'h55);

    // Reset on the 5th valid cycle aborts the dump
    dump_start = 1;
    step();
    dump_start = 0;
    for (int c = 1; c < 5; c++) step();
    chk("abort pre idx", 32'(idx), 32'd4);
    reset = 1;
    step();
    reset = 0;
    chk("abort valid", 32'(valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort index", 32'(idx), 32'd0);
    chk("abort value", dval, 32'd0);
    readReg1 = 4'h6; readReg2 = 4'h7;
    #1;
    chk("abort sp", rv1, 32'h100);
    chk("abort r7", rv2, 32'h0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || valid) ndone++;
      step();
    end
    chk("abort quiet", 32'(ndone), 32'd0);

    exp_regs[0] = 0;
    exp_regs[2] = 0;
    exp_regs[3] = 0;
    exp_regs[6] = 32'h100;
    full_dump("post_abort");
    chk("nb idle", 32'(n_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
